// File: rtl/demux_pkg.sv
// Shared types and defaults for the demux_sched controller.
//   state_e    : controller state (IDLE waits for a word, HOLD presents it)
//   *_DEF      : default channel count, select width and data width
//   MODE_RR    : mode value for round-robin target selection
//   MODE_DIR   : mode value for directed target selection (uses dest)
package demux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int N_OUT_DEF = 8;
  localparam int SEL_W_DEF = 3;
  localparam int DW_DEF    = 8;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

endpackage

// File: rtl/demux_sched_if.sv
// Bus bundle between the upstream source, the scheduler and the N downstream
// channels that share one data bus.
//   mode, dest, in_valid, in_data, in_ready : upstream valid/ready side
//   out_ready, out_valid, out_data, sel     : shared downstream side
// master : the environment (upstream source plus downstream channels)
// slave  : the scheduler itself
interface demux_sched_if
  import demux_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int DW    = DW_DEF
);

  logic             mode;
  logic [SEL_W-1:0] dest;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [N_OUT-1:0] out_ready;
  logic [N_OUT-1:0] out_valid;
  logic [DW-1:0]    out_data;
  logic [SEL_W-1:0] sel;

  modport master (
    output mode, dest, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, sel
  );

  modport slave (
    input  mode, dest, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, sel
  );

endinterface

// File: rtl/rr_find_first.sv
// Rotating priority search: returns the first set bit of req, scanning from
// index start upward and wrapping past N_OUT-1 back to 0.
//   req   : request vector, one bit per channel
//   start : index with highest priority
//   idx   : first requesting index at or after start (start when none)
//   found : at least one request bit is set
// Purely combinational.
module rr_find_first #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_OUT-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [2*N_OUT-1:0] req_dbl;
  logic [N_OUT-1:0]   req_rot;

  // Doubling the vector turns the wrap-around scan into a plain shift:
  // bit i of req_rot is channel (start + i) mod N_OUT.
  assign req_dbl = {req, req} >> start;
  assign req_rot = req_dbl[N_OUT-1:0];

  always_comb begin
    // NOTE: every output gets a default before the loop so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    idx   = start;
    found = 1'b0;
    // Scan from the far end so the lowest rotated offset is written last.
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        idx   = SEL_W'((int'(start) + i) % N_OUT);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_sched.sv
// Scheduler for a 1-to-N output demultiplexer. Holds one upstream word and
// presents it to exactly one channel, chosen by dest (directed mode) or by
// round-robin over the channels ready at accept time. A word nobody accepts
// within TIMEOUT cycles is dropped and counted.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   bus      : upstream and downstream handshake bundle (slave side)
//   busy     : a word is currently held
//   drop_cnt : saturating count of words dropped by timeout
module demux_sched
  import demux_pkg::*;
#(
  parameter int N_OUT   = N_OUT_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  demux_sched_if.slave  bus,
  output logic          busy,
  output logic [7:0]    drop_cnt
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] rr_ptr_q;
  logic [N_OUT-1:0] out_valid_q;
  logic [DW-1:0]    data_q;
  logic             mode_q;
  logic [CNT_W-1:0] wait_q;
  logic [7:0]       drop_cnt_q;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_found;
  logic [SEL_W-1:0] accept_sel;
  logic [SEL_W-1:0] ptr_after;
  logic             handshake;
  logic             timeout_hit;

  rr_find_first #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_rr_find_first (
    .req   (bus.out_ready),
    .start (rr_ptr_q),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // With no ready channel in RR mode the word still waits on rr_ptr.
  assign accept_sel = (bus.mode == MODE_DIR) ? bus.dest
                    : (rr_found ? rr_idx : rr_ptr_q);

  assign ptr_after = (int'(sel_q) == N_OUT - 1) ? '0 : sel_q + SEL_W'(1);

  // Only the selected channel's ready matters; out_valid_q is one-hot at
  // sel_q throughout HOLD, so it need not appear in the term.
  assign handshake   = (state_q == HOLD) && bus.out_ready[sel_q];
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    // NOTE: all state is assigned non-blocking so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= '0;
      data_q      <= '0;
      mode_q      <= MODE_RR;
      wait_q      <= '0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q     <= HOLD;
            data_q      <= bus.in_data;
            mode_q      <= bus.mode;
            sel_q       <= accept_sel;
            out_valid_q <= N_OUT'(1) << accept_sel;
            wait_q      <= '0;
          end
        end
        HOLD: begin
          // A handshake on the timeout cycle takes priority over the drop.
          if (handshake || timeout_hit) begin
            state_q     <= IDLE;
            out_valid_q <= '0;
            wait_q      <= '0;
            if (mode_q == MODE_RR) begin
              rr_ptr_q <= ptr_after;
            end
            if (!handshake && (drop_cnt_q != 8'hFF)) begin
              drop_cnt_q <= drop_cnt_q + 8'd1;
            end
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Gating with rst_n keeps in_ready low during the reset cycle itself.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
  assign busy          = (state_q == HOLD);
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_demux_sched.sv
module tb_demux_sched;
  import demux_pkg::*;

  localparam int N_OUT   = 8;
  localparam int SEL_W   = 3;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    int         ch;
    logic [7:0] data;
    bit         delivered;
    int         hold;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] drop_cnt;

  demux_sched_if #(.N_OUT(N_OUT), .SEL_W(SEL_W), .DW(DW)) bus ();

  demux_sched #(
    .N_OUT   (N_OUT),
    .SEL_W   (SEL_W),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  int   rr_ptr    = 0;
  int   drv_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: picks the target from the rules, pushes the outcome,
  // then plays the downstream side. Target ready rises on HOLD cycle d.
  task automatic send(input bit m, input int dst, input logic [7:0] data,
                      input logic [7:0] rdy_acc, input int d);
    exp_t e;
    int   ch;
    bit   hit;
    int   waitc;
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (m) begin
      ch = dst;
    end else begin
      ch  = rr_ptr;
      hit = 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        if (!hit && rdy_acc[(rr_ptr + k) % N_OUT]) begin
          ch  = (rr_ptr + k) % N_OUT;
          hit = 1'b1;
        end
      end
    end
    e.ch        = ch;
    e.data      = data;
    e.delivered = (d < TIMEOUT);
    e.hold      = e.delivered ? d + 1 : TIMEOUT;
    if (!m) rr_ptr = (ch + 1) % N_OUT;
    if (!e.delivered) drv_drops++;
    sb.push_back(e);
    bus.in_valid  = 1'b1;
    bus.mode      = m;
    bus.dest      = dst[SEL_W-1:0];
    bus.in_data   = data;
    bus.out_ready = rdy_acc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = DW'($urandom);
    for (int i = 0; i < e.hold; i++) begin
      logic [7:0] nz;
      nz            = 8'($urandom);
      nz[ch]        = (i == d);
      bus.out_ready = nz;
      bus.mode      = 1'($urandom);
      bus.dest      = SEL_W'($urandom);
      @(posedge clk); #1;
    end
    bus.out_ready = '0;
  endtask

  // Monitor: tracks each held word and pops the scoreboard on delivery or drop.
  int         hold_cnt  = 0;
  int         mon_drops = 0;
  bit         prev_busy = 1'b0;
  bit         ended     = 1'b0;
  logic [2:0] cap_sel;
  logic [7:0] cap_data;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
      ended     = 1'b0;
      hold_cnt  = 0;
      mon_drops = 0;
    end else if (busy) begin
      hold_cnt++;
      check("valid_onehot", {24'd0, bus.out_valid}, 32'd1 << bus.sel);
      check("in_ready_hold", {31'd0, bus.in_ready}, 32'd0);
      if (hold_cnt == 1) begin
        cap_sel  = bus.sel;
        cap_data = bus.out_data;
      end else begin
        check("sel_stable", {29'd0, bus.sel}, {29'd0, cap_sel});
        check("data_stable", {24'd0, bus.out_data}, {24'd0, cap_data});
      end
      if (!ended && bus.out_ready[bus.sel]) begin
        ended = 1'b1;
        if (sb.size() == 0) begin
          check("deliver_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("deliver_outcome", 32'd1, {31'd0, e.delivered});
          check("deliver_sel", {29'd0, bus.sel}, e.ch);
          check("deliver_data", {24'd0, bus.out_data}, {24'd0, e.data});
          check("deliver_hold", hold_cnt, e.hold);
          check("deliver_drop_cnt", {24'd0, drop_cnt}, mon_drops);
        end
      end
      prev_busy = 1'b1;
    end else begin
      if (prev_busy && !ended) begin
        if (sb.size() == 0) begin
          check("drop_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (mon_drops < 255) mon_drops++;
          check("drop_outcome", 32'd0, {31'd0, e.delivered});
          check("drop_sel", {29'd0, cap_sel}, e.ch);
          check("drop_data", {24'd0, cap_data}, {24'd0, e.data});
          check("drop_hold", hold_cnt, e.hold);
          check("drop_cnt", {24'd0, drop_cnt}, mon_drops);
        end
      end
      check("idle_valid", {24'd0, bus.out_valid}, 32'd0);
      prev_busy = 1'b0;
      ended     = 1'b0;
      hold_cnt  = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = MODE_RR;
    bus.dest      = '0;
    bus.out_ready = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {24'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_sel", {29'd0, bus.sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed delivery with immediate handshake.
    send(MODE_DIR, 5, 8'hA5, 8'hFF, 0);
    // RR fairness: ten words with everyone ready.
    for (int i = 0; i < 10; i++) send(MODE_RR, 0, 8'(8'h10 + i), 8'hFF, 0);
    // Advance rr_ptr from 2 to 6, then skip-and-wrap.
    for (int i = 0; i < 4; i++) send(MODE_RR, 0, 8'(8'h20 + i), 8'hFF, 0);
    send(MODE_RR, 0, 8'h31, 8'h05, 0);
    send(MODE_RR, 0, 8'h32, 8'h05, 0);
    // Timeout: drop, then handshake exactly on the last HOLD cycle.
    send(MODE_DIR, 3, 8'h41, 8'h00, TIMEOUT);
    send(MODE_DIR, 3, 8'h42, 8'h00, TIMEOUT - 1);
    // RR with no ready channel at accept waits on rr_ptr.
    send(MODE_RR, 0, 8'h43, 8'h00, 2);

    for (int n = 0; n < 120; n++) begin
      logic [7:0] r;
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      send(1'($urandom), int'($urandom_range(0, N_OUT - 1)), 8'($urandom), r,
           int'($urandom_range(0, 19)));
    end

    check("drop_cnt_total", {24'd0, drop_cnt}, drv_drops);
    check("sb_drained", sb.size(), 32'd0);

    // Reset in the middle of HOLD discards the word.
    bus.in_valid  = 1'b1;
    bus.mode      = MODE_DIR;
    bus.dest      = 3'd4;
    bus.in_data   = 8'h3C;
    bus.out_ready = '0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {24'd0, bus.out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_sel", {29'd0, bus.sel}, 32'd0);
    check("midrst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("midrst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    check("midrst_in_ready_after", {31'd0, bus.in_ready}, 32'd1);
    rr_ptr    = 0;
    drv_drops = 0;
    @(posedge clk); #1;

    // rr_ptr restarts at 0 and drop counting restarts from zero.
    send(MODE_RR, 0, 8'h51, 8'hFF, 0);
    send(MODE_DIR, 6, 8'h52, 8'hFF, TIMEOUT + 2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("final_drop_cnt", {24'd0, drop_cnt}, drv_drops);
    check("final_sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
- Controller that sequences the 1-to-N output demultiplexer.
- Accepts words from a single valid/ready upstream and holds each one in a one-entry buffer.
- Delivers each word to exactly one of N downstream channels. The channel is either the one named in `dest` (directed mode) or the next ready channel in round-robin order (RR mode).
- Drives the demux select, so all N channels share one data bus. Channels that never accept a word cause it to be dropped after a timeout.

Parameters:
- N_OUT, 8, number of output channels.
- SEL_W, 3, select width; must equal clog2(N_OUT).
- DW, 8, data word width.
- TIMEOUT, 16, maximum HOLD cycles before a word is dropped; 0 disables dropping.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = round-robin, 1 = directed; sampled only on accept.
- dest  in  SEL_W  target channel in directed mode; sampled only on accept.
- in_valid  in  1  upstream word valid.
- in_data  in  DW  upstream word.
- in_ready  out  1  block can accept a word.
- out_ready  in  N_OUT  per-channel ready.
- out_valid  out  N_OUT  per-channel valid; one-hot or zero.
- out_data  out  DW  held word, shared by all channels.
- sel  out  SEL_W  current demux select, which is the target channel.
- busy  out  1  a word is held.
- drop_cnt  out  8  saturating count of words dropped by timeout.

Behaviour:
- Reset: all of the following hold, and any held word is discarded with no handshake.
  - state = IDLE
  - in_ready = 0 during the reset cycle
  - out_valid = 0, out_data = 0, sel = 0
  - busy = 0, drop_cnt = 0
  - rr_ptr = 0
  - wait counter = 0
- States:
  - IDLE: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, busy = 1, out_valid = one-hot(sel).
- IDLE→HOLD on in_valid at cycle T:
  - Capture in_data into out_data.
  - Directed mode: sel ← dest.
  - RR mode: sel ← first index k, scanning from rr_ptr upward with wrap, where out_ready[k] = 1 as sampled at T. If no channel is ready, sel ← rr_ptr.
  - out_valid[sel] asserts at T+1. Accept-to-valid latency is 1 cycle.
- HOLD→IDLE on handshake (out_valid[sel] & out_ready[sel]):
  - Word is delivered.
  - RR mode: rr_ptr ← (sel+1) mod N_OUT.
  - Directed mode: rr_ptr is unchanged.
  - Wait counter clears.
- HOLD, no handshake:
  - Wait counter increments.
  - When TIMEOUT ≠ 0 and the counter reaches TIMEOUT−1 without a handshake: return to IDLE, drop the word, and increment drop_cnt (saturates at 255).
  - On an RR-mode drop, rr_ptr also advances to sel+1.
- A handshake on the timeout cycle wins: the word is delivered, not dropped.
- Valid stability: once out_valid[sel] rises it stays high, and sel and out_data stay constant, until handshake or drop. No retargeting while in HOLD.
- out_valid is registered and never depends combinationally on out_ready.
- Throughput: at most 1 word per 2 cycles, because in_ready is low while in HOLD.
- out_ready of channels other than sel is ignored while in HOLD.
- mode and dest changes while in HOLD have no effect until the next accept.
- rr_ptr wrap: N_OUT−1 + 1 → 0.
- If reset asserts while in HOLD, the next cycle is IDLE with all outputs at their reset values.

Decomposition:
- Package demux_pkg:
  - state enum {IDLE, HOLD}
  - default N_OUT and SEL_W
  - MODE_RR / MODE_DIR constants
- Sub-module rr_find_first:
  - Inputs: req[N_OUT], start[SEL_W].
  - Outputs: idx[SEL_W], found.
  - Purely combinational rotating priority search.
  - Instantiated once and unit-testable on its own.

Test Plan:
- Directed delivery: reset, mode = 1, dest = 5, in_data = 0xA5 accepted at T, out_ready = 0xFF → out_valid = 0x20 and sel = 5 at T+1, out_data = 0xA5, handshake at T+1, in_ready = 1 at T+2.
- RR fairness: mode = 0, out_ready = 0xFF, send 10 words → sel sequence 0,1,2,3,4,5,6,7,0,1; drop_cnt = 0.
- RR skip and wrap: rr_ptr = 6, out_ready = 0x05 at accept → sel = 0; after the handshake, rr_ptr = 1. Next accept with out_ready = 0x05 → sel = 2.
- Timeout drop: TIMEOUT = 16, dest = 3, out_ready = 0 → out_valid = 0x08 for exactly 16 cycles, then IDLE with drop_cnt = 1. With out_ready[3] = 1 on the last HOLD cycle → delivered, drop_cnt unchanged.
- Stability and sampling: in HOLD with sel = 2, change dest to 7 and mode to 0, and toggle out_ready[7:3] → sel, out_valid and out_data are unchanged until out_ready[2] = 1.
- Reset mid-HOLD: rst_n = 0 for one cycle during HOLD → next cycle out_valid = 0, busy = 0, sel = 0, drop_cnt = 0, in_ready = 1 after rst_n deasserts.
